serial_adder: RTL and testbench

- Bit-serial ripple adder that computes Sum = A + B + Cin over WIDTH clock cycles, LSB first.
- A single combinational 1-bit full-adder cell is used for every bit, and a registered carry links one bit to the next.
- Operands enter through a valid/ready handshake; the result leaves through a second valid/ready handshake.
- Sits directly downstream of the combinational adder cells and trades area for latency in the arithmetic mini-projects.

---
 rtl/arith_pkg.sv | 8 +
 rtl/full_adder_cell.sv | 21 ++
 rtl/serial_adder.sv | 106 ++++++++++
 tb/tb_serial_adder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared types and defaults for the serial arithmetic blocks
package arith_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} serial_state_t;

  localparam int SERIAL_WIDTH = 8;

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - combinational 1-bit full adder from two half-adder stages
module full_adder_cell (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  logic p;
  logic g1;
  logic g2;

  // first half adder on the operands, second folds in the carry
  assign p    = A ^ B;
  assign g1   = A & B;
  assign Sum  = p ^ Cin;
  assign g2   = p & Cin;
  assign Cout = g1 | g2;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, LSB first, one full-adder cell and a registered carry
module serial_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  serial_state_t    state;
  serial_state_t    state_nxt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;
  logic             accept;
  logic             last;

  full_adder_cell u_fa (
    .A    (opa[0]),
    .B    (opb[0]),
    .Cin  (carry),
    .Sum  (fa_sum),
    .Cout (fa_cout)
  );

  assign accept = in_valid && in_ready;
  assign last   = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // result bits enter at the top so the LSB ends up at bit 0 after WIDTH shifts
  always_ff @(posedge clk) begin
    if (rst) begin
      opa    <= '0;
      opb    <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            opa   <= A;
            opb   <= B;
            carry <= Cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          sum_q <= {fa_sum, sum_q[WIDTH-1:1]};
          carry <= fa_cout;
          cnt   <= cnt + 1'b1;
          if (last) cout_q <= fa_cout;
        end
        default: begin
        end
      endcase
    end
  end

  assign Sum  = sum_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Sum;
  logic         Cout;

  int compared   = 0;
  int mismatched = 0;

  logic [W:0] exp_q[$];
  logic [W:0] held;
  logic       holding = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // result monitor: stability under backpressure and scoreboard pop on handshake
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      check("in_ready_in_done", in_ready, 0);
      if (holding) check("hold_stable", {Cout, Sum}, held);
      held    = {Cout, Sum};
      holding = 1'b1;
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", {Cout, Sum}, {(W+1){1'b1}} ^ {Cout, Sum});
        end else begin
          check("result", {Cout, Sum}, exp_q.pop_front());
        end
        holding = 1'b0;
      end
    end else begin
      holding = 1'b0;
    end
  end

  // called just after a rising edge while the block is idle
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input int hold, input bit noise);
    int n;
    logic [W:0] e;
    check("idle_before", in_ready, 1);
    in_valid  = 1'b1;
    A         = a;
    B         = b;
    Cin       = c;
    out_ready = 1'b0;
    e = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    exp_q.push_back(e);
    @(posedge clk); #1;
    if (noise) begin
      A   = '1;
      B   = '1;
      Cin = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, W);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("idle_after", in_ready, 1);
    check("valid_after", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    Cin       = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", Sum, 0);
    check("rst_cout", Cout, 0);

    do_op(8'h00, 8'h00, 1'b0, 0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    do_op(8'h3C, 8'h0F, 1'b0, 1, 1'b0);
    do_op(8'hA5, 8'h5A, 1'b1, 0, 1'b0);
    do_op(8'h80, 8'h80, 1'b0, 5, 1'b0);

    // request presented during RUN/DONE must be ignored
    do_op(8'h12, 8'h34, 1'b0, 2, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      check("not_consumed_ready", in_ready, 1);
      check("not_consumed_valid", out_valid, 0);
    end

    // abort in the third RUN cycle
    in_valid = 1'b1;
    A        = 8'h55;
    B        = 8'h55;
    Cin      = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_sum", Sum, 0);
    repeat (W + 2) @(posedge clk);
    #1;
    check("abort_no_pulse", out_valid, 0);
    do_op(8'h01, 8'h02, 1'b0, 0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      do_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), i % 3, 1'(i % 2));
    end

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
